// File: rtl/split_timestamp_pkg.sv
// -----------------------------------------------------------------------------
// split_timestamp_pkg
// Shared definitions for the timestamp attach/split paths: default beat and
// trailer widths, the trailer beat-count derivation and the splitter state
// encoding. Both paths import this package so the trailer layout (least
// significant chunk first) is defined in exactly one place.
// -----------------------------------------------------------------------------
package split_timestamp_pkg;

    localparam int DEFAULT_DATA_WIDTH      = 8;
    localparam int DEFAULT_TIMESTAMP_WIDTH = 72;

    // Number of beats a trailer occupies on the byte stream.
    function automatic int ts_beat_num(input int data_width, input int timestamp_width);
        return timestamp_width / data_width;
    endfunction

    localparam int DEFAULT_TIMESTAMP_BEAT_NUM =
        ts_beat_num(DEFAULT_DATA_WIDTH, DEFAULT_TIMESTAMP_WIDTH);

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_FLUSH   = 1'b1
    } split_state_t;

endpackage

// File: rtl/timestamp_holdbuf.sv
// -----------------------------------------------------------------------------
// timestamp_holdbuf
// Delay line that holds back the most recent BEAT_NUM beats of a packet so a
// trailer of BEAT_NUM beats can be stripped without buffering the whole frame.
// Storage is an (BEAT_NUM-1)-beat shift register SR feeding a pending beat P.
//
// Ports:
//   clk, rstn  - clock, synchronous active-low reset (clears the fill count)
//   in_data    - beat to shift in
//   shift      - shift in_data into SR; SR oldest moves into P
//   clear      - drop all held beats (fill count back to 0)
//   count      - number of valid beats held (0..BEAT_NUM)
//   evict      - shift while full: the beat in P leaves the buffer this cycle
//   pending    - P, the beat that leaves on the next evict
//   sr_flat    - SR contents, oldest beat in the least significant chunk
// -----------------------------------------------------------------------------
module timestamp_holdbuf
    import split_timestamp_pkg::*;
#(
    parameter int  DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int  BEAT_NUM   = DEFAULT_TIMESTAMP_BEAT_NUM,
    localparam int CNT_W      = $clog2(BEAT_NUM + 1)
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [DATA_WIDTH-1:0]          in_data,
    input  logic                           shift,
    input  logic                           clear,
    output logic [CNT_W-1:0]               count,
    output logic                           evict,
    output logic [DATA_WIDTH-1:0]          pending,
    output logic [(BEAT_NUM-1)*DATA_WIDTH-1:0] sr_flat
);

    // sr[0] is the oldest beat, sr[BEAT_NUM-2] the newest.
    logic [DATA_WIDTH-1:0] sr [BEAT_NUM-1];

    logic full;
    assign full  = (count == CNT_W'(BEAT_NUM));
    assign evict = shift & full;

    // NOTE: the data storage has no reset; count alone says which beats are
    // meaningful, so resetting the beats would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (shift) begin
            pending <= sr[0];
            for (int i = 0; i < BEAT_NUM - 2; i++) begin
                sr[i] <= sr[i+1];
            end
            sr[BEAT_NUM-2] <= in_data;
        end
    end

    // NOTE: non-blocking assignments for all clocked state, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (shift && !full) begin
            count <= count + CNT_W'(1);
        end
    end

    // NOTE: give every combinational output a default before conditional or
    // partial assignments so no latch is inferred.
    always_comb begin
        sr_flat = '0;
        for (int i = 0; i < BEAT_NUM - 1; i++) begin
            sr_flat[i*DATA_WIDTH +: DATA_WIDTH] = sr[i];
        end
    end

endmodule

// File: rtl/split_timestamp.sv
// -----------------------------------------------------------------------------
// split_timestamp
// Splits a byte stream of [frame][timestamp trailer] into a plain frame stream
// and one timestamp word per frame. The trailer is TIMESTAMP_BEAT_NUM beats,
// least significant chunk first. Packets too short to carry trailer plus one
// frame beat are dropped and flagged with runt_error.
//
// Ports:
//   clk, rstn               - clock, synchronous active-low reset
//   s_axis_*                - frame+trailer input (tdata/tvalid/tready/tlast)
//   m_axis_*                - frame-only output, tlast on last frame beat
//   m_axis_timestamp_*      - extracted timestamp (tdata/tvalid/tready)
//   runt_error              - one-cycle pulse per dropped runt packet
// -----------------------------------------------------------------------------
module split_timestamp
    import split_timestamp_pkg::*;
#(
    parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int TIMESTAMP_WIDTH = DEFAULT_TIMESTAMP_WIDTH
) (
    input  logic                       clk,
    input  logic                       rstn,

    input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tlast,

    output logic [DATA_WIDTH-1:0]      m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,

    output logic [TIMESTAMP_WIDTH-1:0] m_axis_timestamp_tdata,
    output logic                       m_axis_timestamp_tvalid,
    input  logic                       m_axis_timestamp_tready,

    output logic                       runt_error
);

    localparam int BEAT_NUM = ts_beat_num(DATA_WIDTH, TIMESTAMP_WIDTH);
    localparam int CNT_W    = $clog2(BEAT_NUM + 1);

    split_state_t state, next_state;

    // Output register O and timestamp register T.
    logic                       o_valid, o_last;
    logic [DATA_WIDTH-1:0]      o_data;
    logic                       t_valid;
    logic [TIMESTAMP_WIDTH-1:0] t_data;

    logic                               s_accept, beat_shift, last_ok, runt_hit;
    logic                               hb_full;
    logic [CNT_W-1:0]                   hb_count;
    logic                               hb_evict;
    logic [DATA_WIDTH-1:0]              hb_pending;
    logic [(BEAT_NUM-1)*DATA_WIDTH-1:0] hb_sr_flat;

    assign s_accept   = s_axis_tvalid & s_axis_tready;
    assign hb_full    = (hb_count == CNT_W'(BEAT_NUM));
    assign beat_shift = s_accept & ~s_axis_tlast;
    assign last_ok    = s_accept &  s_axis_tlast &  hb_full;
    assign runt_hit   = s_accept &  s_axis_tlast & ~hb_full;

    timestamp_holdbuf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BEAT_NUM   (BEAT_NUM)
    ) u_holdbuf (
        .clk     (clk),
        .rstn    (rstn),
        .in_data (s_axis_tdata),
        .shift   (beat_shift),
        .clear   (s_accept & s_axis_tlast),
        .count   (hb_count),
        .evict   (hb_evict),
        .pending (hb_pending),
        .sr_flat (hb_sr_flat)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= ST_COLLECT;
        end else begin
            state <= next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        next_state = state;
        unique case (state)
            ST_COLLECT: if (last_ok) next_state = ST_FLUSH;
            // Leave FLUSH once both holding registers are empty or being
            // emptied this cycle, so the next packet can start immediately.
            ST_FLUSH: if ((!o_valid || m_axis_tready) &&
                          (!t_valid || m_axis_timestamp_tready))
                          next_state = ST_COLLECT;
            default: next_state = ST_COLLECT;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        s_axis_tready = 1'b0;
        if (state == ST_COLLECT) begin
            s_axis_tready = !o_valid || m_axis_tready;
        end
    end

    // ---------------- Frame output register O ----------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_data  <= '0;
        end else if (hb_evict || last_ok) begin
            // On the tlast beat, P holds the final frame beat.
            o_data  <= hb_pending;
            o_last  <= last_ok;
            o_valid <= 1'b1;
        end else if (m_axis_tready) begin
            o_valid <= 1'b0;
        end
    end

    // ---------------- Timestamp register T ----------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            t_valid <= 1'b0;
            t_data  <= '0;
        end else if (last_ok) begin
            // SR oldest becomes the least significant chunk, the incoming
            // tlast beat the most significant one.
            t_data  <= {s_axis_tdata, hb_sr_flat};
            t_valid <= 1'b1;
        end else if (m_axis_timestamp_tready) begin
            t_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            runt_error <= 1'b0;
        end else begin
            runt_error <= runt_hit;
        end
    end

    assign m_axis_tdata            = o_data;
    assign m_axis_tvalid           = o_valid;
    assign m_axis_tlast            = o_last;
    assign m_axis_timestamp_tdata  = t_data;
    assign m_axis_timestamp_tvalid = t_valid;

endmodule

// File: doc/split_timestamp.md
# split_timestamp

Receive-side counterpart of the timestamp-attach path: accepts a byte stream of `[Ethernet frame]/[timestamp trailer]` and separates it into a plain frame stream and a single timestamp word. The trailer is TIMESTAMP_BEAT_NUM beats, least-significant chunk first, and every packet on the input carries one. The block sits downstream of the frame FIFO that stores timestamped frames, and upstream of the ATS eligibility and transmit logic. Trailing-beat detection uses an N-beat holding buffer, so there is no store-and-forward of the whole frame.

## Interface
- DATA_WIDTH, 8, beat width in bits
- TIMESTAMP_WIDTH, 72, trailer width; multiple of DATA_WIDTH; TIMESTAMP_BEAT_NUM = TIMESTAMP_WIDTH/DATA_WIDTH ≥ 2
- clk  in  1  single clock for all logic
- rstn  in  1  reset; synchronous, active-low
- s_axis_tdata / tvalid / tready / tlast  in/in/out/in  DATA_WIDTH/1/1/1  frame plus trailer input
- m_axis_tdata / tvalid / tready / tlast  out/out/in/out  DATA_WIDTH/1/1/1  frame only, tlast on the last frame byte
- m_axis_timestamp_tdata / tvalid / tready  out/out/in  TIMESTAMP_WIDTH/1/1  extracted timestamp, one per frame
- runt_error  out  1  one-cycle pulse when an input packet is too short to hold trailer plus one frame beat

## Operation
- Notation: N = TIMESTAMP_BEAT_NUM.
- Storage:
  - shift register SR of N-1 beats;
  - pending beat P;
  - output register O (data, last, valid);
  - timestamp register T (data, valid);
  - fill count C (0..N).
- States are COLLECT and FLUSH.
- COLLECT: s_axis_tready = !O.valid | m_axis_tready.
- COLLECT, non-last beat accepted:
  - C<N: shift the beat into SR, then P; C++.
  - C==N: O <= {P, last=0}; P <= SR oldest; shift the beat into SR.
- COLLECT, last beat accepted with C==N:
  - O <= {P, last=1};
  - T.data <= {incoming, SR newest…oldest}, i.e. SR oldest lands in bits [DATA_WIDTH-1:0] and incoming lands in the top chunk;
  - T.valid <= 1; C <= 0; go to FLUSH.
- COLLECT, last beat accepted with C<N: runt. Discard all held beats, pulse runt_error, C <= 0, no frame output, no timestamp, stay in COLLECT.
- FLUSH:
  - s_axis_tready = 0.
  - O drains on m_axis_tready; T drains on m_axis_timestamp_tready, independently and in either order.
  - Return to COLLECT in the cycle when both are empty, or are emptied in that same cycle.
- An all-zero timestamp is passed through unchanged; zero filtering is upstream's job.
- m_axis outputs come directly from O; m_axis_timestamp outputs come directly from T. No combinational path from s_axis_* to m_axis_*.

## Timing
- Reset (rstn=0 at a clk edge):
  - state=COLLECT, C=0;
  - O.valid=0, O.last=0, O.data=0;
  - T.valid=0, T.data=0;
  - runt_error=0.
  - s_axis_tready=1 from the first cycle after release.
- Reset mid-frame discards all held beats; downstream sees no partial frame tail.
- Latency: a frame beat reaches m_axis one cycle after the input beat that arrives N beats behind it. The last frame beat and the timestamp become valid one cycle after the input tlast beat.
- Throughput: 1 beat/cycle inside a packet while m_axis_tready=1.
  - The inter-packet gap is at least 1 cycle (FLUSH), longer if either consumer stalls.
  - The first N input beats of a packet are accepted with m_axis_tvalid=0.
- Backpressure: tvalid, tdata and tlast on O and T stay stable until accepted.
- Minimum legal packet is N+1 beats, giving a 1-beat frame. N beats or fewer is a runt.
- Last input beat arriving while O is full and m_axis_tready=0: not accepted, because tready=0.

## Structure
- Shared include holds:
  - default DATA_WIDTH=8;
  - TIMESTAMP_WIDTH=72;
  - the TIMESTAMP_BEAT_NUM derivation;
  - the state encodings (COLLECT=0, FLUSH=1).
- The attach and split blocks both use this include, so trailer order cannot diverge between them.
- One natural sub-module, timestamp_holdbuf: the SR+P delay line with C, shift and evict outputs. It is reusable by other trailer-stripping paths.

## Test plan
1. 64-byte frame 0x00..0x3F plus trailer bytes 01,EF,CD,AB,89,67,45,23,01, m ready always:
   - m_axis carries 64 bytes 0x00..0x3F, with tlast on 0x3F only;
   - timestamp = 72'h01_23456789_ABCDEF01, exactly once;
   - runt_error never pulses.
2. 10-beat packet 0xAA followed by a 9-byte trailer: one-beat frame 0xAA with tlast=1, and the timestamp is correct. Then an 8-beat packet: runt_error pulses once, with no m_axis or timestamp output.
3. Random m_axis_tready (50%) and a timestamp consumer held off for 20 cycles after tlast:
   - byte sequence identical to test 1;
   - s_axis_tready=0 throughout the hold;
   - the next packet starts only after both outputs drain.
4. Two back-to-back 64-byte frames with distinct timestamps: both are split correctly, with a gap of exactly 1 cycle at full ready.
5. rstn asserted at input beat 30 of a frame, then a clean 64-byte frame: no beats of the aborted frame ever appear, and the clean frame and its timestamp are correct.
6. All-zero trailer: frame and timestamp 72'h0 are both delivered.
